// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV memory front end.
//   - Requester index constants for the four traffic sources.
//   - Address and response-data widths used by every SpMV block.
//   - The tag-table entry recorded per in-flight transaction ID.
//   - rr_next: round-robin pointer advance helper.
package spmv_pkg;

    // Requester indices into the arbiter's per-requester port vectors.
    localparam int unsigned REQ_VEC    = 0;
    localparam int unsigned REQ_ROWPTR = 1;
    localparam int unsigned REQ_COLIDX = 2;
    localparam int unsigned REQ_VAL    = 3;

    // Widths of a physical line address and of a NoC response payload.
    localparam int unsigned PADDR_W    = 48;
    localparam int unsigned RES_DATA_W = 64;

    // Tag-table fields are sized for the largest supported configuration.
    // Narrower instances zero-extend on write and slice on read.
    localparam int unsigned TBL_OWNER_W = 4;
    localparam int unsigned TBL_TAG_W   = 16;

    typedef struct packed {
        logic [TBL_OWNER_W-1:0] owner;
        logic [TBL_TAG_W-1:0]   tag;
    } tag_entry_t;

    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/spmv_tid_pool.sv
// Transaction-ID pool.
// Holds a free bit per ID, picks the lowest-numbered free ID, and counts
// IDs in flight.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   alloc             take alloc_id this cycle (ignored when nothing is free)
//   free, free_id     return free_id to the pool at the next edge
//   query_id          ID to look up; query_busy=1 when it is allocated
//   any_free          at least one ID is free
//   alloc_id          lowest-numbered free ID
//   outstanding       number of allocated IDs
module spmv_tid_pool #(
    parameter int unsigned TID_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic             free,
    input  logic [TID_W-1:0] free_id,
    input  logic [TID_W-1:0] query_id,
    output logic             query_busy,
    output logic             any_free,
    output logic [TID_W-1:0] alloc_id,
    output logic [TID_W:0]   outstanding
);

    localparam int unsigned NUM_ID = 2 ** TID_W;

    logic [NUM_ID-1:0] free_q, free_d;
    logic [TID_W:0]    cnt_q, cnt_d;
    logic              do_alloc;

    // Lowest free wins: scan downward so the last hit is the smallest index.
    always_comb begin
        alloc_id = '0;
        for (int i = NUM_ID - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_id = TID_W'(i);
            end
        end
    end

    assign any_free   = |free_q;
    assign query_busy = ~free_q[query_id];
    assign do_alloc   = alloc && any_free;

    // A freed ID only reappears in free_q after the edge, so it cannot be
    // handed out in the same cycle its response arrives.
    always_comb begin
        free_d = free_q;
        if (free) begin
            free_d[free_id] = 1'b1;
        end
        if (do_alloc) begin
            free_d[alloc_id] = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_alloc, free})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q <= '1;
            cnt_q  <= '0;
        end else begin
            free_q <= free_d;
            cnt_q  <= cnt_d;
        end
    end

    assign outstanding = cnt_q;

endmodule

// File: rtl/spmv_mem_arb.sv
// SpMV memory request arbiter.
// Round-robin arbitration of NUM_REQ requesters into a one-entry output stage,
// transaction-ID allocation, and routing of memory responses back to the
// requester that owns each ID.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_val/req_addr/req_tag      per-requester request
//   req_rdy                       per-requester accept (one-hot or zero)
//   mem_req_val/rdy/addr/transid  memory request channel
//   mem_resp_val/transid/data     memory response channel
//   resp_val/resp_tag/resp_data   routed response (resp_val one-hot)
//   outstanding                   IDs in flight
//   idle                          nothing in flight, stage empty, no requests
//   err_spurious                  sticky: response seen on an unallocated ID
module spmv_mem_arb
    import spmv_pkg::*;
#(
    parameter int unsigned NUM_REQ = REQ_VAL + 1,
    parameter int unsigned TID_W   = 6,
    parameter int unsigned TAG_W   = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_val,
    input  logic [NUM_REQ-1:0][PADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
    output logic [NUM_REQ-1:0]               req_rdy,
    output logic                             mem_req_val,
    input  logic                             mem_req_rdy,
    output logic [PADDR_W-1:0]               mem_req_addr,
    output logic [TID_W-1:0]                 mem_req_transid,
    input  logic                             mem_resp_val,
    input  logic [TID_W-1:0]                 mem_resp_transid,
    input  logic [RES_DATA_W-1:0]            mem_resp_data,
    output logic [NUM_REQ-1:0]               resp_val,
    output logic [TAG_W-1:0]                 resp_tag,
    output logic [RES_DATA_W-1:0]            resp_data,
    output logic [TID_W:0]                   outstanding,
    output logic                             idle,
    output logic                             err_spurious
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_ID = 2 ** TID_W;

    // Output stage and arbiter state.
    logic               stage_val_q;
    logic [PADDR_W-1:0] stage_addr_q;
    logic [TID_W-1:0]   stage_tid_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic               err_q;

    tag_entry_t tag_tbl [NUM_ID];

    logic             stage_can_accept;
    logic             found;
    logic [PTR_W-1:0] win;
    logic             grant;
    logic             any_free;
    logic [TID_W-1:0] alloc_id;
    logic             query_busy;
    logic             resp_hit;
    logic             resp_spurious;
    tag_entry_t       new_entry;
    tag_entry_t       resp_entry;
    logic             unused_entry_bits;

    // Stage refills when empty or when its current content leaves this cycle.
    assign stage_can_accept = !stage_val_q || mem_req_rdy;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_val[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign grant = found && stage_can_accept && any_free && !rst;

    always_comb begin
        req_rdy = '0;
        if (grant) begin
            req_rdy[win] = 1'b1;
        end
    end

    spmv_tid_pool #(
        .TID_W (TID_W)
    ) u_tid_pool (
        .clk         (clk),
        .rst         (rst),
        .alloc       (grant),
        .free        (resp_hit),
        .free_id     (mem_resp_transid),
        .query_id    (mem_resp_transid),
        .query_busy  (query_busy),
        .any_free    (any_free),
        .alloc_id    (alloc_id),
        .outstanding (outstanding)
    );

    always_comb begin
        new_entry       = '0;
        new_entry.owner = TBL_OWNER_W'(win);
        new_entry.tag   = TBL_TAG_W'(req_tag[win]);
    end

    // The table is only ever read at allocated IDs, so it needs no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_tbl[alloc_id] <= new_entry;
        end
    end

    // Response routing is purely combinational off the table lookup.
    assign resp_entry    = tag_tbl[mem_resp_transid];
    assign resp_hit      = mem_resp_val && query_busy && !rst;
    assign resp_spurious = mem_resp_val && !query_busy;

    always_comb begin
        resp_val = '0;
        if (resp_hit) begin
            resp_val[resp_entry.owner[PTR_W-1:0]] = 1'b1;
        end
    end

    assign resp_tag  = resp_entry.tag[TAG_W-1:0];
    assign resp_data = mem_resp_data;

    // Upper table bits exist only for wider configurations.
    assign unused_entry_bits = ^resp_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_val_q  <= 1'b0;
            stage_addr_q <= '0;
            stage_tid_q  <= '0;
            rr_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            if (stage_can_accept) begin
                stage_val_q <= grant;
            end
            if (grant) begin
                stage_addr_q <= req_addr[win];
                stage_tid_q  <= alloc_id;
                rr_ptr_q     <= PTR_W'(rr_next(32'(win), NUM_REQ));
            end
            if (resp_spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_req_val     = stage_val_q;
    assign mem_req_addr    = stage_addr_q;
    assign mem_req_transid = stage_tid_q;
    assign err_spurious    = err_q;
    assign idle            = (outstanding == '0) && !stage_val_q && (req_val == '0);

endmodule

// File: tb/tb_spmv_mem_arb.sv
module tb_spmv_mem_arb;
    import spmv_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TIDW = 6;
    localparam int unsigned TAGW = 10;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NREQ-1:0]               req_val;
    logic [NREQ-1:0][PADDR_W-1:0]  req_addr;
    logic [NREQ-1:0][TAGW-1:0]     req_tag;
    logic [NREQ-1:0]               req_rdy;
    logic                          mem_req_val;
    logic                          mem_req_rdy;
    logic [PADDR_W-1:0]            mem_req_addr;
    logic [TIDW-1:0]               mem_req_transid;
    logic                          mem_resp_val;
    logic [TIDW-1:0]               mem_resp_transid;
    logic [RES_DATA_W-1:0]         mem_resp_data;
    logic [NREQ-1:0]               resp_val;
    logic [TAGW-1:0]               resp_tag;
    logic [RES_DATA_W-1:0]         resp_data;
    logic [TIDW:0]                 outstanding;
    logic                          idle;
    logic                          err_spurious;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spmv_mem_arb #(
        .NUM_REQ (NREQ),
        .TID_W   (TIDW),
        .TAG_W   (TAGW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_val          (req_val),
        .req_addr         (req_addr),
        .req_tag          (req_tag),
        .req_rdy          (req_rdy),
        .mem_req_val      (mem_req_val),
        .mem_req_rdy      (mem_req_rdy),
        .mem_req_addr     (mem_req_addr),
        .mem_req_transid  (mem_req_transid),
        .mem_resp_val     (mem_resp_val),
        .mem_resp_transid (mem_resp_transid),
        .mem_resp_data    (mem_resp_data),
        .resp_val         (resp_val),
        .resp_tag         (resp_tag),
        .resp_data        (resp_data),
        .outstanding      (outstanding),
        .idle             (idle),
        .err_spurious     (err_spurious)
    );

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_val          = '0;
        req_addr         = '0;
        req_tag          = '0;
        mem_req_rdy      = 1'b0;
        mem_resp_val     = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL reset_memval got=%0h exp=0", mem_req_val); end
        total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b exp=0000", req_rdy); end
        total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL reset_outst got=%0d exp=0", outstanding); end
        total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err_spurious); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0h exp=1", idle); end
    endtask

    task automatic test_single();
        do_reset();
        req_val[REQ_VEC]  = 1'b1;
        req_addr[REQ_VEC] = 48'h1000;
        req_tag[REQ_VEC]  = 10'd5;
        #1;
        total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL single_rdy got=%b exp=0001", req_rdy); end
        tick();
        req_val = '0;
        #1;
        total++; if (mem_req_val !== 1'b1) begin bad++; $display("FAIL single_memval got=%0h exp=1", mem_req_val); end
        total++; if (mem_req_transid !== 6'd0) begin bad++; $display("FAIL single_tid got=%0d exp=0", mem_req_transid); end
        total++; if (mem_req_addr !== 48'h1000) begin bad++; $display("FAIL single_addr got=%h exp=1000", mem_req_addr); end
        total++; if (outstanding !== 7'd1) begin bad++; $display("FAIL single_outst got=%0d exp=1", outstanding); end
        mem_req_rdy = 1'b1;
        tick();
        total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL single_drain got=%0h exp=0", mem_req_val); end
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd0;
        mem_resp_data    = 64'hDEAD_BEEF_0123_4567;
        #1;
        total++; if (resp_val !== 4'b0001) begin bad++; $display("FAIL single_respval got=%b exp=0001", resp_val); end
        total++; if (resp_tag !== 10'd5) begin bad++; $display("FAIL single_resptag got=%0d exp=5", resp_tag); end
        total++; if (resp_data !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL single_respdata got=%h exp=deadbeef01234567", resp_data); end
        tick();
        mem_resp_val = 1'b0;
        #1;
        total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL single_freed got=%0d exp=0", outstanding); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%0h exp=1", idle); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 48'h2000 + 48'(i * 64);
            req_tag[i]  = 10'(16 + i);
        end
        req_val     = 4'b1111;
        mem_req_rdy = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'(1 << (k % 4));
            total++; if (req_rdy !== exp_rdy) begin bad++; $display("FAIL rr_rdy%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
            tick();
            total++; if (mem_req_transid !== 6'(k)) begin bad++; $display("FAIL rr_tid%0d got=%0d exp=%0d", k, mem_req_transid, k); end
            total++; if (mem_req_addr !== 48'h2000 + 48'((k % 4) * 64)) begin bad++; $display("FAIL rr_addr%0d got=%h", k, mem_req_addr); end
            total++; if (mem_req_val !== 1'b1) begin bad++; $display("FAIL rr_val%0d got=%0h exp=1", k, mem_req_val); end
        end
        req_val = '0;
        tick();
        total++; if (outstanding !== 7'd5) begin bad++; $display("FAIL rr_outst got=%0d exp=5", outstanding); end
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd3;
        #1;
        total++; if (resp_val !== 4'b1000) begin bad++; $display("FAIL rr_respval got=%b exp=1000", resp_val); end
        total++; if (resp_tag !== 10'd19) begin bad++; $display("FAIL rr_resptag got=%0d exp=19", resp_tag); end
        tick();
        mem_resp_val = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_val[REQ_VEC]     = 1'b1;
        req_addr[REQ_VEC]    = 48'h3000;
        req_tag[REQ_VEC]     = 10'd7;
        req_addr[REQ_ROWPTR] = 48'h3040;
        req_tag[REQ_ROWPTR]  = 10'd8;
        tick();
        req_val = 4'b0010;
        #1;
        for (int c = 0; c < 5; c++) begin
            total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL bp_rdy%0d got=%b exp=0000", c, req_rdy); end
            total++; if (mem_req_addr !== 48'h3000) begin bad++; $display("FAIL bp_addr%0d got=%h exp=3000", c, mem_req_addr); end
            total++; if (mem_req_transid !== 6'd0) begin bad++; $display("FAIL bp_tid%0d got=%0d exp=0", c, mem_req_transid); end
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL bp_release got=%b exp=0010", req_rdy); end
        tick();
        req_val = '0;
        #1;
        total++; if (mem_req_addr !== 48'h3040) begin bad++; $display("FAIL bp_next_addr got=%h exp=3040", mem_req_addr); end
        total++; if (mem_req_transid !== 6'd1) begin bad++; $display("FAIL bp_next_tid got=%0d exp=1", mem_req_transid); end
        tick();
        total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL bp_one_issue got=%0h exp=0", mem_req_val); end
    endtask

    task automatic test_pool_full();
        do_reset();
        mem_req_rdy      = 1'b1;
        req_val[REQ_VEC] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            req_tag[REQ_VEC]  = 10'(i);
            req_addr[REQ_VEC] = 48'h4000 + 48'(i);
            tick();
        end
        total++; if (outstanding !== 7'd64) begin bad++; $display("FAIL full_outst got=%0d exp=64", outstanding); end
        total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL full_rdy got=%b exp=0000", req_rdy); end
        total++; if (mem_req_transid !== 6'd63) begin bad++; $display("FAIL full_lasttid got=%0d exp=63", mem_req_transid); end
        tick();
        total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL full_drain got=%0h exp=0", mem_req_val); end
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd17;
        #1;
        total++; if (resp_val !== 4'b0001) begin bad++; $display("FAIL full_respval got=%b exp=0001", resp_val); end
        total++; if (resp_tag !== 10'd17) begin bad++; $display("FAIL full_resptag got=%0d exp=17", resp_tag); end
        total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL full_nosame got=%b exp=0000", req_rdy); end
        tick();
        mem_resp_val = 1'b0;
        #1;
        total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL full_regrant got=%b exp=0001", req_rdy); end
        total++; if (outstanding !== 7'd63) begin bad++; $display("FAIL full_outst63 got=%0d exp=63", outstanding); end
        tick();
        req_val = '0;
        #1;
        total++; if (mem_req_transid !== 6'd17) begin bad++; $display("FAIL full_tid17 got=%0d exp=17", mem_req_transid); end
        total++; if (mem_req_val !== 1'b1) begin bad++; $display("FAIL full_val17 got=%0h exp=1", mem_req_val); end
        total++; if (outstanding !== 7'd64) begin bad++; $display("FAIL full_outst64b got=%0d exp=64", outstanding); end
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd9;
        #1;
        total++; if (resp_val !== 4'b0000) begin bad++; $display("FAIL spur_respval got=%b exp=0000", resp_val); end
        tick();
        mem_resp_val = 1'b0;
        tick();
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%0h exp=1", err_spurious); end
        // Burst, then reset with transactions in flight.
        req_val     = 4'b1111;
        mem_req_rdy = 1'b1;
        tick();
        tick();
        tick();
        total++; if (outstanding !== 7'd3) begin bad++; $display("FAIL burst_outst got=%0d exp=3", outstanding); end
        rst     = 1'b1;
        req_val = '0;
        #1;
        total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL mrst_memval got=%0h exp=0", mem_req_val); end
        total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL mrst_rdy got=%b exp=0000", req_rdy); end
        total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL mrst_outst got=%0d exp=0", outstanding); end
        total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL mrst_err got=%0h exp=0", err_spurious); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL mrst_idle got=%0h exp=1", idle); end
        tick();
        rst = 1'b0;
        req_val = 4'b1111;
        mem_req_rdy = 1'b0;
        #1;
        total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL mrst_rrptr got=%b exp=0001", req_rdy); end
        req_val          = '0;
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'd1;
        #1;
        total++; if (resp_val !== 4'b0000) begin bad++; $display("FAIL mrst_stale got=%b exp=0000", resp_val); end
        tick();
        mem_resp_val = 1'b0;
        #1;
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL mrst_spur got=%0h exp=1", err_spurious); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_pool_full();
        test_spurious_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
